// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: size encodings, FSM states and the queued entry payload.
package store_buffer_pkg;

  localparam int unsigned SB_ADDR_W = 64;
  localparam int unsigned SB_DATA_W = 64;
  localparam int unsigned SB_BE_W   = SB_DATA_W / 8;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } sb_state_e;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    logic [SB_BE_W-1:0]   be;
  } sb_entry_t;

  // Unshifted byte-enable pattern for an access size.
  function automatic logic [SB_BE_W-1:0] size_be(input logic [1:0] size);
    case (size)
      SZ_B:    size_be = 8'h01;
      SZ_H:    size_be = 8'h03;
      SZ_W:    size_be = 8'h0F;
      default: size_be = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane steering: size masking, byte-lane shift, byte enables and misalignment detect.
module store_lane_align
  import store_buffer_pkg::*;
(
  input  logic [2:0]           i_offset,
  input  logic [1:0]           i_size,
  input  logic [SB_DATA_W-1:0] i_data,
  output logic                 o_misalign,
  output logic [SB_DATA_W-1:0] o_wdata,
  output logic [SB_BE_W-1:0]   o_be
);

  logic [SB_DATA_W-1:0] w_mask;

  always_comb begin
    w_mask     = '1;
    o_misalign = 1'b0;
    case (i_size)
      SZ_B: begin
        w_mask     = 64'h0000_0000_0000_00FF;
        o_misalign = 1'b0;
      end
      SZ_H: begin
        w_mask     = 64'h0000_0000_0000_FFFF;
        o_misalign = i_offset[0];
      end
      SZ_W: begin
        w_mask     = 64'h0000_0000_FFFF_FFFF;
        o_misalign = |i_offset[1:0];
      end
      default: begin
        w_mask     = '1;
        o_misalign = |i_offset;
      end
    endcase
    o_wdata = (i_data & w_mask) << {i_offset, 3'b000};
    o_be    = size_be(i_size) << i_offset;
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer draining to the data-memory write port over a valid/ack handshake.
// Optional load-forwarding search is enabled by defining STORE_BUFFER_FWD_EN.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = SB_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [SB_DATA_W-1:0]    req_data,
  input  logic [1:0]              req_size,
  output logic                    misalign,
  output logic                    mem_wr_en,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [SB_DATA_W-1:0]    mem_wdata,
  output logic [SB_BE_W-1:0]      mem_be,
  input  logic                    mem_ack,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
`ifdef STORE_BUFFER_FWD_EN
  ,
  input  logic [ADDR_W-1:0]       fwd_addr,
  output logic                    fwd_hit,
  output logic [SB_DATA_W-1:0]    fwd_data
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  sb_entry_t            r_mem [DEPTH];
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;
  logic                 r_misalign;
  sb_state_e            r_state;
  sb_state_e            w_state_next;

  logic                 w_misalign;
  logic [SB_DATA_W-1:0] w_wdata;
  logic [SB_BE_W-1:0]   w_be;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic [CNT_W-1:0]     w_count_next;
  sb_entry_t            w_entry;
  sb_entry_t            w_head;

  store_lane_align u_align (
    .i_offset   (req_addr[2:0]),
    .i_size     (req_size),
    .i_data     (req_data),
    .o_misalign (w_misalign),
    .o_wdata    (w_wdata),
    .o_be       (w_be)
  );

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign req_ready = !full;
  assign count     = r_count;
  assign misalign  = r_misalign;

  assign w_accept     = req_valid && !full;
  assign w_push       = w_accept && !w_misalign;
  assign w_pop        = (r_state == WRITE) && mem_ack;
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_head       = r_mem[r_head];

  always_comb begin
    w_entry      = '0;
    w_entry.addr = SB_ADDR_W'({req_addr[ADDR_W-1:3], 3'b000});
    w_entry.data = w_wdata;
    w_entry.be   = w_be;
  end

  // Entry storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= w_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      r_count    <= w_count_next;
      r_misalign <= w_accept && w_misalign;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Head entry is presented only while writing; outputs hold until the ack pops it.
  always_comb begin
    w_state_next = r_state;
    mem_wr_en    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_be       = '0;
    case (r_state)
      IDLE: begin
        if (r_count != '0) w_state_next = WRITE;
      end
      WRITE: begin
        mem_wr_en = 1'b1;
        mem_addr  = ADDR_W'(w_head.addr);
        mem_wdata = w_head.data;
        mem_be    = w_head.be;
        if (mem_ack && (w_count_next == '0)) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [SB_ADDR_W-1:0] w_fwd_line;
  logic [PTR_W-1:0]     w_idx;

  // Walk oldest to youngest so the youngest full-doubleword match wins.
  always_comb begin
    fwd_hit    = 1'b0;
    fwd_data   = '0;
    w_idx      = '0;
    w_fwd_line = SB_ADDR_W'({fwd_addr[ADDR_W-1:3], 3'b000});
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_mem[w_idx].addr == w_fwd_line) &&
          (r_mem[w_idx].be == 8'hFF)) begin
        fwd_hit  = 1'b1;
        fwd_data = r_mem[w_idx].data;
      end
    end
  end
`endif

endmodule
